// File: rtl/hex_score_display.sv
// Decimal seven-segment driver: sequential double-dabble of a signed/unsigned score,
// with sign, leading-zero blanking, overflow dashes and a registered decimal-point mask.
//   state   | meaning
//   S_IDLE  | waiting for start, display holds last committed digits
//   S_SHIFT | one double-dabble step per cycle, BIN_WIDTH cycles
//   S_COMMIT| encode BCD into segments, pulse done
module hex_score_display #(
  parameter int NUM_DIGITS    = 6,
  parameter int BIN_WIDTH     = 20,
  parameter int SIGNED        = 1,
  parameter int LEADING_BLANK = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [8*NUM_DIGITS-1:0] hex_seg,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  function automatic int digits_for(input int w);
    longint m;
    int     n;
    m = (longint'(1) << w) - 1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (m > 0) begin
        m = m / 10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int BCD_DIGITS = digits_for(BIN_WIDTH);
  localparam int MAX_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(BIN_WIDTH);

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt;
  logic [BIN_WIDTH-1:0]        mag, mag_in;
  logic                        neg, neg_in;
  logic [BCD_W-1:0]            bcd, bcd_adj;
  logic [BCD_W+BIN_WIDTH-1:0]  shifted;
  logic [4*MAX_DIGITS-1:0]     bcd_pad;
  logic [7*NUM_DIGITS-1:0]     seg7, seg7_nxt;
  logic [NUM_DIGITS-1:0]       dp_q;
  logic                        ovf_nxt;
  logic                        seen_nonzero;
  logic [3:0]                  dig;
  int                          avail;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SHIFT;
      S_SHIFT:  if (cnt == '0) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // Negation done in BIN_WIDTH unsigned so the most negative value converts exactly.
  assign neg_in  = (SIGNED != 0) && value[BIN_WIDTH-1];
  assign mag_in  = neg_in ? (BIN_WIDTH'(0) - value) : value;
  assign shifted = {bcd_adj, mag} << 1;
  assign bcd_pad = (4*MAX_DIGITS)'(bcd);

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    avail        = neg ? NUM_DIGITS - 1 : NUM_DIGITS;
    ovf_nxt      = 1'b0;
    seen_nonzero = 1'b0;
    dig          = 4'd0;
    seg7_nxt     = '1;
    for (int j = 0; j < MAX_DIGITS; j++) begin
      if (j >= avail && bcd_pad[4*j +: 4] != 4'd0) ovf_nxt = 1'b1;
    end
    // Walk from the top so seen_nonzero marks digits at or below the leading nonzero one.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig = bcd_pad[4*i +: 4];
      if (dig != 4'd0) seen_nonzero = 1'b1;
      if (ovf_nxt || (neg && i == NUM_DIGITS - 1))
        seg7_nxt[7*i +: 7] = 7'h3F;
      else if (LEADING_BLANK != 0 && !seen_nonzero && i != 0)
        seg7_nxt[7*i +: 7] = 7'h7F;
      else
        seg7_nxt[7*i +: 7] = seg_encode(dig);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt      <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      bcd      <= '0;
      seg7     <= '1;
      dp_q     <= '1;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dp_q <= ~dp_mask;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mag <= mag_in;
            neg <= neg_in;
            bcd <= '0;
            cnt <= CNT_W'(BIN_WIDTH - 1);
          end
        end
        S_SHIFT: begin
          bcd <= shifted[BCD_W+BIN_WIDTH-1 -: BCD_W];
          mag <= shifted[BIN_WIDTH-1:0];
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_COMMIT: begin
          seg7     <= seg7_nxt;
          overflow <= ovf_nxt;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hex_seg = '1;
    for (int i = 0; i < NUM_DIGITS; i++) hex_seg[8*i +: 8] = {dp_q[i], seg7[7*i +: 7]};
  end

endmodule

// File: tb/tb_hex_score_display.sv
// Bench for hex_score_display: default build plus an unsigned, non-blanking build
// driven in parallel, checked against an arithmetic decimal model through a scoreboard.
module tb_hex_score_display;
  localparam int ND = 6;
  localparam int BW = 20;

  typedef struct packed {
    logic [7*ND-1:0] seg;
    logic            ovf;
  } exp_t;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            start;
  logic [BW-1:0]   value;
  logic [ND-1:0]   dp_mask;
  logic [8*ND-1:0] hex_m, hex_a;
  logic            busy_m, busy_a, done_m, done_a, ovf_m, ovf_a;

  int checks = 0;
  int errors = 0;

  exp_t            q_m[$];
  exp_t            q_a[$];
  logic [7*ND-1:0] cur_m, cur_a;
  logic            cur_ovf_m, cur_ovf_a;
  int              mbusy;
  logic            exp_done;
  logic [ND-1:0]   dp_q;

  hex_score_display #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .SIGNED(1), .LEADING_BLANK(1)) u_main (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .value(value), .dp_mask(dp_mask),
    .hex_seg(hex_m), .busy(busy_m), .done(done_m), .overflow(ovf_m));

  hex_score_display #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .SIGNED(0), .LEADING_BLANK(0)) u_alt (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .value(value), .dp_mask(dp_mask),
    .hex_seg(hex_a), .busy(busy_a), .done(done_a), .overflow(ovf_a));

  always #10 Clk = ~Clk;

  function automatic logic [6:0] enc7(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // Decimal digits by repeated division of the integer magnitude.
  function automatic exp_t model(input logic [BW-1:0] v, input bit sgn, input bit lb);
    exp_t   e;
    longint mag, lim, t;
    bit     neg;
    int     avail, msd;
    int     d [ND];
    neg   = sgn && v[BW-1];
    mag   = neg ? (longint'(1) << BW) - longint'(v) : longint'(v);
    avail = neg ? ND - 1 : ND;
    lim   = 1;
    for (int k = 0; k < avail; k++) lim = lim * 10;
    e.ovf = (mag >= lim);
    t   = mag;
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      d[i] = int'(t % 10);
      t    = t / 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++) begin
      if (e.ovf || (neg && i == ND - 1)) e.seg[7*i +: 7] = 7'h3F;
      else if (lb && i > msd)            e.seg[7*i +: 7] = 7'h7F;
      else                               e.seg[7*i +: 7] = enc7(d[i]);
    end
    return e;
  endfunction

  function automatic logic [8*ND-1:0] with_dp(input logic [7*ND-1:0] s, input logic [ND-1:0] dpb);
    logic [8*ND-1:0] o;
    for (int i = 0; i < ND; i++) o[8*i +: 8] = {dpb[i], s[7*i +: 7]};
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference timing: accepted start makes the block busy for BW+1 edges.
  initial begin
    mbusy = 0; exp_done = 1'b0; dp_q = '1;
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        mbusy = 0; exp_done = 1'b0; dp_q = '1;
        q_m.delete(); q_a.delete();
      end else begin
        exp_done = (mbusy == 1);
        dp_q     = ~dp_mask;
        if (mbusy == 0 && start) begin
          q_m.push_back(model(value, 1'b1, 1'b1));
          q_a.push_back(model(value, 1'b0, 1'b0));
          mbusy = BW + 1;
        end else if (mbusy > 0) begin
          mbusy = mbusy - 1;
        end
      end
    end
  end

  // Monitor: pops on DUT done, and checks held display, busy and done every cycle.
  initial begin
    exp_t e;
    cur_m = '1; cur_a = '1; cur_ovf_m = 1'b0; cur_ovf_a = 1'b0;
    forever begin
      @(negedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        cur_m = '1; cur_a = '1; cur_ovf_m = 1'b0; cur_ovf_a = 1'b0;
      end else begin
        chk("busy_main", busy_m, mbusy != 0);
        chk("busy_alt",  busy_a, mbusy != 0);
        chk("done_main", done_m, exp_done);
        chk("done_alt",  done_a, exp_done);
        if (done_m) begin
          if (q_m.size() == 0) chk("scoreboard_main_empty", 1, 0);
          else begin e = q_m.pop_front(); cur_m = e.seg; cur_ovf_m = e.ovf; end
        end
        if (done_a) begin
          if (q_a.size() == 0) chk("scoreboard_alt_empty", 1, 0);
          else begin e = q_a.pop_front(); cur_a = e.seg; cur_ovf_a = e.ovf; end
        end
        chk("seg_main", hex_m, with_dp(cur_m, dp_q));
        chk("seg_alt",  hex_a, with_dp(cur_a, dp_q));
        chk("ovf_main", ovf_m, cur_ovf_m);
        chk("ovf_alt",  ovf_a, cur_ovf_a);
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_hex_main"},  hex_m,  {8*ND{1'b1}});
    chk({tag, "_hex_alt"},   hex_a,  {8*ND{1'b1}});
    chk({tag, "_busy_main"}, busy_m, 0);
    chk({tag, "_done_main"}, done_m, 0);
    chk({tag, "_ovf_main"},  ovf_m,  0);
    chk({tag, "_busy_alt"},  busy_a, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Clk);
    while (mbusy != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (mbusy != 0) begin
      errors++;
      $display("FAIL idle_timeout actual=%0d required=0", mbusy);
    end
  endtask

  task automatic issue(input logic [BW-1:0] v, input int hold);
    @(negedge Clk);
    start = 1'b1;
    value = v;
    repeat (hold) @(negedge Clk);
    start = 1'b0;
    value = BW'($urandom);
  endtask

  task automatic run(input logic [BW-1:0] v);
    issue(v, 1);
    wait_idle();
  endtask

  initial begin
    logic [BW-1:0] bnd [6];
    logic [BW-1:0] v;
    bnd = '{20'd99999, 20'd100000, 20'd999999, 20'hE7961, 20'hE7960, 20'h7FFFF};

    Reset_n = 1'b0; start = 1'b1; value = 20'd5; dp_mask = '0;
    repeat (3) @(posedge Clk);
    #1 reset_checks("reset");
    @(negedge Clk); start = 1'b0;
    @(posedge Clk); #2 Reset_n = 1'b1;
    repeat (5) @(negedge Clk);

    run(20'd0);
    issue(20'd123456, 1);
    repeat (5) @(negedge Clk);
    start = 1'b1; value = 20'd7;
    @(negedge Clk); start = 1'b0;
    wait_idle();
    run(20'd7);
    run(20'hFFFD6);
    @(negedge Clk); dp_mask = 6'b000100;
    repeat (3) @(negedge Clk); dp_mask = '0;
    run(20'h80000);
    run(20'd524287);
    run(20'hFFFFF);

    issue(20'd999, 1);
    repeat (10) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 reset_checks("abort");
    repeat (2) @(posedge Clk);
    #2 Reset_n = 1'b1;
    run(20'd999);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v = BW'($urandom_range(0, 999));
        1:       v = BW'(0 - int'($urandom_range(0, 99999)));
        2:       v = bnd[$urandom_range(0, 5)];
        default: v = BW'($urandom);
      endcase
      dp_mask = ND'($urandom);
      issue(v, ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 24)) : 1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 8)) @(negedge Clk);
        start = 1'b1; value = BW'($urandom);
        @(negedge Clk); start = 1'b0;
      end
      wait_idle();
      wait_idle();
    end

    repeat (3) @(negedge Clk);
    chk("queue_main_drained", q_m.size(), 0);
    chk("queue_alt_drained",  q_a.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
